// File: rtl/xbar_pkg.sv
// rtl/xbar_pkg.sv - shared crossbar types and the grant-to-ID decoder
// Contents: N_MASTERS, mst_id_t, id_dec_t, onehot2id()
package xbar_pkg;

   localparam int N_MASTERS = 2;

   typedef logic mst_id_t;

   typedef struct packed {
      logic    valid;
      mst_id_t id;
   } id_dec_t;

   // Only a one-hot grant names a master; 00 and 11 decode as invalid.
   function automatic id_dec_t onehot2id(input logic [N_MASTERS-1:0] grnt);
      id_dec_t r;
      r.valid = 1'b0;
      r.id    = 1'b0;
      case (grnt)
         2'b01: begin r.valid = 1'b1; r.id = 1'b0; end
         2'b10: begin r.valid = 1'b1; r.id = 1'b1; end
         default: ;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/resp_router_if.sv
// rtl/resp_router_if.sv - request/response handshake bundle of the return path
// Slave side: grant + request accept in, slave response in, per-master response out,
//             outstanding count, stall and sticky error flags out.
// Master side: the mirror image, used by whatever drives the router.
interface resp_router_if #(
   parameter int DATA_W = 32,
   parameter int DEPTH  = 4
);
   localparam int CNT_W = $clog2(DEPTH + 1);

   logic [1:0]        grnt;
   logic              s_req;
   logic              s_ack;
   logic              s_resp_valid;
   logic [DATA_W-1:0] s_resp_data;
   logic              s_resp_err;
   logic              s_resp_ready;
   logic [1:0]        m_resp_valid;
   logic [DATA_W-1:0] m_resp_data;
   logic              m_resp_err;
   logic [1:0]        m_resp_ready;
   logic [CNT_W-1:0]  outstanding;
   logic              stall;
   logic              err_grnt;
   logic              err_orphan;

   modport slave (
      input  grnt, s_req, s_ack, s_resp_valid, s_resp_data, s_resp_err, m_resp_ready,
      output s_resp_ready, m_resp_valid, m_resp_data, m_resp_err,
             outstanding, stall, err_grnt, err_orphan
   );

   modport master (
      output grnt, s_req, s_ack, s_resp_valid, s_resp_data, s_resp_err, m_resp_ready,
      input  s_resp_ready, m_resp_valid, m_resp_data, m_resp_err,
             outstanding, stall, err_grnt, err_orphan
   );
endinterface

// File: rtl/id_fifo.sv
// rtl/id_fifo.sv - in-order FIFO of granted master IDs
// Ports: clk, resetn (async, active low), push/din, pop/dout,
//        full (registered), empty, count (0..DEPTH).
module id_fifo
   import xbar_pkg::*;
#(
   parameter  int DEPTH = 4,
   localparam int CNT_W = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic             push,
   input  logic             pop,
   input  mst_id_t          din,
   output mst_id_t          dout,
   output logic             full,
   output logic             empty,
   output logic [CNT_W-1:0] count
);
   localparam int PTR_W = $clog2(DEPTH);

   mst_id_t          mem_q [DEPTH];
   mst_id_t          mem_d [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             full_q, full_d;
   logic             do_push, do_pop;

   assign empty = (count_q == '0);
   assign full  = full_q;
   assign count = count_q;
   assign dout  = mem_q[rd_ptr_q];

   always_comb begin
      // A push is refused whenever full, even if a pop frees a slot this cycle.
      do_push  = push && !full_q;
      do_pop   = pop && !empty;
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (do_push) begin
         mem_d[wr_ptr_q] = din;
         wr_ptr_d        = wr_ptr_q + PTR_W'(1);
      end
      if (do_pop) begin
         rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      if (do_push && !do_pop) begin
         count_d = count_q + CNT_W'(1);
      end else if (!do_push && do_pop) begin
         count_d = count_q - CNT_W'(1);
      end
      full_d = (count_d == CNT_W'(DEPTH));
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         mem_q    <= '{default: 1'b0};
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         full_q   <= 1'b0;
      end else begin
         mem_q    <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         full_q   <= full_d;
      end
   end

endmodule

// File: rtl/resp_router.sv
// rtl/resp_router.sv - slave-side response router of the 2-master crossbar
// Ports: clk, resetn (async, active low), bus (resp_router_if.slave):
//        grant/accept in -> ID FIFO; slave response -> one-entry output stage ->
//        per-master response; outstanding/stall out; sticky err_grnt/err_orphan.
module resp_router
   import xbar_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int DEPTH  = 4
) (
   input  logic        clk,
   input  logic        resetn,
   resp_router_if.slave bus
);
   localparam int CNT_W = $clog2(DEPTH + 1);

   id_dec_t           dec;
   logic              accept, push, capture, drain;
   logic              fifo_full, fifo_empty;
   mst_id_t           head_id;
   logic [CNT_W-1:0]  fifo_count;
   logic              s_ready;
   logic [1:0]        m_valid;

   logic              out_valid_q, out_valid_d;
   mst_id_t           out_id_q, out_id_d;
   logic [DATA_W-1:0] out_data_q, out_data_d;
   logic              out_err_q, out_err_d;
   logic              err_grnt_q, err_grnt_d;
   logic              err_orphan_q, err_orphan_d;

   assign dec    = onehot2id(bus.grnt);
   assign accept = bus.s_req && bus.s_ack;
   assign push   = accept && dec.valid && !fifo_full;

   id_fifo #(.DEPTH(DEPTH)) u_id_fifo (
      .clk    (clk),
      .resetn (resetn),
      .push   (push),
      .pop    (capture),
      .din    (dec.id),
      .dout   (head_id),
      .full   (fifo_full),
      .empty  (fifo_empty),
      .count  (fifo_count)
   );

   always_comb begin
      drain   = out_valid_q && bus.m_resp_ready[out_id_q];
      // With nothing outstanding the response is an orphan and is swallowed.
      s_ready = fifo_empty || !out_valid_q || drain;
      capture = bus.s_resp_valid && s_ready && !fifo_empty;

      out_valid_d = out_valid_q;
      out_id_d    = out_id_q;
      out_data_d  = out_data_q;
      out_err_d   = out_err_q;
      if (capture) begin
         out_valid_d = 1'b1;
         out_id_d    = head_id;
         out_data_d  = bus.s_resp_data;
         out_err_d   = bus.s_resp_err;
      end else if (drain) begin
         out_valid_d = 1'b0;
      end

      err_grnt_d   = err_grnt_q || (accept && (!dec.valid || fifo_full));
      err_orphan_d = err_orphan_q || (bus.s_resp_valid && fifo_empty);

      m_valid           = 2'b00;
      m_valid[out_id_q] = out_valid_q;
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         out_valid_q  <= 1'b0;
         out_id_q     <= 1'b0;
         out_data_q   <= '0;
         out_err_q    <= 1'b0;
         err_grnt_q   <= 1'b0;
         err_orphan_q <= 1'b0;
      end else begin
         out_valid_q  <= out_valid_d;
         out_id_q     <= out_id_d;
         out_data_q   <= out_data_d;
         out_err_q    <= out_err_d;
         err_grnt_q   <= err_grnt_d;
         err_orphan_q <= err_orphan_d;
      end
   end

   assign bus.s_resp_ready = s_ready;
   assign bus.m_resp_valid = m_valid;
   assign bus.m_resp_data  = out_data_q;
   assign bus.m_resp_err   = out_err_q;
   assign bus.outstanding  = fifo_count;
   assign bus.stall        = fifo_full;
   assign bus.err_grnt     = err_grnt_q;
   assign bus.err_orphan   = err_orphan_q;

endmodule

// File: tb/tb_resp_router.sv
// tb/tb_resp_router.sv - scoreboard bench for resp_router
module tb_resp_router;
   localparam int DATA_W = 32;
   localparam int DEPTH  = 4;

   typedef struct {
      int          mst;
      logic [31:0] data;
      logic        err;
   } exp_t;

   logic clk = 1'b0;
   logic resetn = 1'b0;
   int   checks = 0;
   int   errors = 0;

   resp_router_if #(.DATA_W(DATA_W), .DEPTH(DEPTH)) rif ();

   resp_router #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
      .clk    (clk),
      .resetn (resetn),
      .bus    (rif)
   );

   always #5 clk = ~clk;

   // Reference model: outstanding IDs in acceptance order, the held response, sticky flags.
   int   id_q[$];
   bit   mo_valid;
   int   mo_id;
   bit   me_grnt, me_orph;
   exp_t exp_q[$];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_clear();
      id_q.delete();
      exp_q.delete();
      mo_valid = 0;
      mo_id    = 0;
      me_grnt  = 0;
      me_orph  = 0;
   endtask

   task automatic idle_inputs();
      rif.grnt = 2'b00; rif.s_req = 0; rif.s_ack = 0;
      rif.s_resp_valid = 0; rif.s_resp_data = '0; rif.s_resp_err = 0;
      rif.m_resp_ready = 2'b00;
   endtask

   // Called at posedge+1; leaves at posedge+1 of the next cycle.
   task automatic cyc(input logic [1:0] g, input logic req, input logic ack, input logic rv,
                      input logic [31:0] rd, input logic re, input logic [1:0] mr);
      bit acc, gok, full, empty, drain, rdy, cap;
      int gid;
      exp_t e;
      rif.grnt = g; rif.s_req = req; rif.s_ack = ack;
      rif.s_resp_valid = rv; rif.s_resp_data = rd; rif.s_resp_err = re;
      rif.m_resp_ready = mr;
      @(negedge clk);
      acc   = req && ack;
      gok   = (g == 2'b01) || (g == 2'b10);
      gid   = (g == 2'b10) ? 1 : 0;
      full  = (id_q.size() == DEPTH);
      empty = (id_q.size() == 0);
      drain = mo_valid && mr[mo_id];
      rdy   = empty || !mo_valid || drain;
      cap   = rv && rdy && !empty;
      chk("outstanding", rif.outstanding, id_q.size());
      chk("stall", rif.stall, full);
      chk("s_resp_ready", rif.s_resp_ready, rdy);
      chk("m_resp_valid", rif.m_resp_valid, mo_valid ? (2'b01 << mo_id) : 2'b00);
      chk("err_grnt", rif.err_grnt, me_grnt);
      chk("err_orphan", rif.err_orphan, me_orph);
      if (cap) begin
         e.mst = id_q.pop_front();
         e.data = rd;
         e.err = re;
         exp_q.push_back(e);
         mo_valid = 1;
         mo_id = e.mst;
      end else if (drain) begin
         mo_valid = 0;
      end
      if (acc && gok && !full) id_q.push_back(gid);
      if (acc && (!gok || full)) me_grnt = 1;
      if (rv && empty) me_orph = 1;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      idle_inputs();
      resetn = 0;
      model_clear();
      @(negedge clk);
      resetn = 1;
      @(posedge clk);
      #1;
   endtask

   // Monitor: every presented response must match the scoreboard head; pop on handshake.
   always @(negedge clk) begin
      if (resetn && rif.m_resp_valid != 2'b00) begin
         if (exp_q.size() == 0) begin
            chk("mon_unexpected_valid", rif.m_resp_valid, 2'b00);
         end else begin
            chk("mon_master", rif.m_resp_valid, 2'b01 << exp_q[0].mst);
            chk("mon_data", rif.m_resp_data, exp_q[0].data);
            chk("mon_err", rif.m_resp_err, exp_q[0].err);
            if ((rif.m_resp_valid & rif.m_resp_ready) != 2'b00) void'(exp_q.pop_front());
         end
      end
   end

   initial begin
      idle_inputs();
      model_clear();
      #12;
      chk("reset_valid", rif.m_resp_valid, 2'b00);
      chk("reset_data", rif.m_resp_data, '0);
      chk("reset_outstanding", rif.outstanding, 0);
      chk("reset_stall", rif.stall, 0);
      @(negedge clk);
      resetn = 1;
      @(posedge clk);
      #1;

      // Single push then response
      cyc(2'b10, 1, 1, 0, 0, 0, 2'b00);
      chk("single_outstanding1", rif.outstanding, 1);
      cyc(2'b00, 0, 0, 1, 32'hA5A5_0001, 0, 2'b00);
      chk("single_valid", rif.m_resp_valid, 2'b10);
      chk("single_data", rif.m_resp_data, 32'hA5A5_0001);
      chk("single_outstanding0", rif.outstanding, 0);
      cyc(2'b00, 0, 0, 0, 0, 0, 2'b10);

      // Interleaved order, fill to DEPTH
      cyc(2'b01, 1, 1, 0, 0, 0, 2'b11);
      cyc(2'b10, 1, 1, 0, 0, 0, 2'b11);
      cyc(2'b01, 1, 1, 0, 0, 0, 2'b11);
      cyc(2'b10, 1, 1, 0, 0, 0, 2'b11);
      chk("interleave_stall", rif.stall, 1);
      for (int i = 0; i < 4; i++) begin
         cyc(2'b00, 0, 0, 1, 32'hD000_0000 + i, i[0], 2'b11);
         chk("interleave_valid", rif.m_resp_valid, (i % 2 == 0) ? 2'b01 : 2'b10);
         chk("interleave_data", rif.m_resp_data, 32'hD000_0000 + i);
      end
      cyc(2'b00, 0, 0, 0, 0, 0, 2'b11);

      // Backpressure
      do_reset();
      cyc(2'b01, 1, 1, 0, 0, 0, 2'b00);
      cyc(2'b10, 1, 1, 0, 0, 0, 2'b00);
      cyc(2'b00, 0, 0, 1, 32'h1111_0000, 0, 2'b00);
      cyc(2'b00, 0, 0, 1, 32'h2222_0000, 1, 2'b00);
      chk("bp_hold_valid", rif.m_resp_valid, 2'b01);
      chk("bp_hold_data", rif.m_resp_data, 32'h1111_0000);
      cyc(2'b00, 0, 0, 1, 32'h2222_0000, 1, 2'b01);
      chk("bp_second_valid", rif.m_resp_valid, 2'b10);
      chk("bp_second_data", rif.m_resp_data, 32'h2222_0000);
      cyc(2'b00, 0, 0, 0, 0, 0, 2'b10);

      // Full with simultaneous pop and accept
      do_reset();
      for (int i = 0; i < 4; i++) cyc(i[0] ? 2'b10 : 2'b01, 1, 1, 0, 0, 0, 2'b11);
      cyc(2'b01, 1, 1, 1, 32'h3333_0000, 0, 2'b11);
      chk("full_pop_outstanding", rif.outstanding, 3);
      chk("full_pop_err_grnt", rif.err_grnt, 1);
      for (int i = 0; i < 4; i++) cyc(2'b00, 0, 0, 1, 32'h4444_0000 + i, 0, 2'b11);

      // Errors
      do_reset();
      cyc(2'b11, 1, 1, 0, 0, 0, 2'b11);
      cyc(2'b00, 0, 0, 1, 32'h5555_0000, 0, 2'b11);
      cyc(2'b00, 0, 0, 0, 0, 0, 2'b11);
      chk("errs_grnt", rif.err_grnt, 1);
      chk("errs_orphan", rif.err_orphan, 1);
      chk("errs_valid", rif.m_resp_valid, 2'b00);
      chk("errs_outstanding", rif.outstanding, 0);

      // Reset mid-flight
      do_reset();
      for (int i = 0; i < 4; i++) cyc(i[0] ? 2'b10 : 2'b01, 1, 1, 0, 0, 0, 2'b00);
      cyc(2'b00, 0, 0, 1, 32'h6666_0000, 1, 2'b00);
      #2;
      resetn = 0;
      #1;
      chk("mid_rst_valid", rif.m_resp_valid, 2'b00);
      chk("mid_rst_data", rif.m_resp_data, '0);
      chk("mid_rst_err", rif.m_resp_err, 0);
      chk("mid_rst_outstanding", rif.outstanding, 0);
      chk("mid_rst_stall", rif.stall, 0);
      idle_inputs();
      model_clear();
      @(negedge clk);
      resetn = 1;
      @(posedge clk);
      #1;
      cyc(2'b10, 1, 1, 0, 0, 0, 2'b00);
      cyc(2'b00, 0, 0, 1, 32'h7777_0000, 0, 2'b10);
      chk("post_rst_valid", rif.m_resp_valid, 2'b10);
      chk("post_rst_data", rif.m_resp_data, 32'h7777_0000);
      cyc(2'b00, 0, 0, 0, 0, 0, 2'b10);

      // Randomized traffic
      do_reset();
      for (int i = 0; i < 3000; i++) begin
         logic [1:0] g;
         int r;
         if (i % 1000 == 999) do_reset();
         r = $urandom_range(0, 19);
         g = (r == 0) ? 2'b11 : (r == 1) ? 2'b00 : (r < 11) ? 2'b01 : 2'b10;
         cyc(g, $urandom_range(0, 1) == 1, $urandom_range(0, 2) != 0,
             $urandom_range(0, 2) != 0, $urandom, $urandom_range(0, 7) == 0,
             2'($urandom_range(0, 3)));
      end
      for (int i = 0; i < 8; i++) cyc(2'b00, 0, 0, (id_q.size() != 0), $urandom, 0, 2'b11);
      chk("scoreboard_drained", exp_q.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/resp_router.md
Name: resp_router

Overview:
Slave-side return path of the 2-master cross bar. It records the arbiter grant each time the slave accepts a request, in a small in-order ID FIFO. It routes each slave response back to the master that issued the request, through a one-entry registered output stage. It also drives a stall output so that no more than DEPTH transactions can be outstanding.

Parameters:
DATA_W, 32, width of the response data bus
DEPTH, 4, maximum outstanding transactions; must be a power of 2 and at least 2
CNT_W, $clog2(DEPTH+1), width of the outstanding count (derived, not overridden)

Ports:
clk  input  1  system clock, rising edge
resetn  input  1  asynchronous active-low reset
grnt  input  2  one-hot grant from the arbiter; bit0 = master0, bit1 = master1
s_req  input  1  request currently presented to the slave
s_ack  input  1  slave accepts the request this cycle
s_resp_valid  input  1  slave response valid
s_resp_data  input  DATA_W  slave response data
s_resp_err  input  1  slave response error flag
s_resp_ready  output  1  router accepts the slave response
m_resp_valid  output  2  per-master response valid (at most one bit set)
m_resp_data  output  DATA_W  response data, shared by both masters
m_resp_err  output  1  response error, shared by both masters
m_resp_ready  input  2  per-master response ready
outstanding  output  CNT_W  number of IDs held in the FIFO
stall  output  1  FIFO full; the arbiter must not grant
err_grnt  output  1  sticky: accept seen with grnt not one-hot
err_orphan  output  1  sticky: response arrived with no outstanding ID

Behaviour:
- Reset (asynchronous, resetn=0):
  - FIFO pointers, count, output stage and sticky errors all clear.
  - m_resp_valid=00, m_resp_data=0, m_resp_err=0, outstanding=0, stall=0.
  - Taking effect mid-operation discards all in-flight IDs and any held response.
- Push:
  - Condition: s_req && s_ack && !full && grnt is 01 or 10.
  - Pushed ID: 0 for grnt=01, 1 for grnt=10.
- Invalid grant on accept: if s_req && s_ack with grnt=00 or 11, nothing is pushed and err_grnt is set. It stays set until reset.
- Accept while full: s_req && s_ack while full means nothing is pushed and err_grnt is set (protocol violation).
- Full:
  - full is registered state (count==DEPTH); stall=full.
  - A push is blocked when full, even if a pop happens in the same cycle. Verification must not expect a same-cycle refill.
- Output stage, one register holding valid, ID, data and err:
  - s_resp_ready = empty || !out_valid || (m_resp_ready[out_id] && out_valid).
  - Capture on s_resp_valid && s_resp_ready && !empty: the stage loads the FIFO head ID, s_resp_data and s_resp_err, and the FIFO pops.
- Latency: the response is visible on m_resp_* in the cycle after the slave handshake. A new capture and a drain may happen in the same cycle, giving full throughput of 1 response per cycle.
- Output drive:
  - m_resp_valid[out_id]=out_valid; the other bit is 0.
  - Data and err hold stable while valid && !ready.
- Orphan response: s_resp_valid while the FIFO is empty is accepted (s_resp_ready=1) and dropped; err_orphan is set (sticky).
- Simultaneous push and pop when not full: count is unchanged, both pointers advance.
- Pointers wrap modulo DEPTH. Count range is 0..DEPTH.
- Ordering: responses are returned strictly in acceptance order, and each response goes only to the master that was granted.

Decomposition:
- Shared package xbar_pkg holds:
  - N_MASTERS=2
  - typedef mst_id_t (1 bit)
  - function onehot2id(grnt), which returns the ID plus a valid bit
- One sub-module: id_fifo, a synchronous FIFO of mst_id_t with DEPTH entries.
  - Ports: push, pop, din, dout, full, empty, count.
  - Uses the same clk and resetn.
- resp_router instantiates id_fifo and contains the output stage and the error flags.

Test Plan:
- Single push then response:
  - Stimulus: grnt=10, accept; then s_resp_data=0xA5A5_0001.
  - Required: the next cycle gives m_resp_valid=10 with that data; outstanding goes 1→0.
- Interleaved order:
  - Stimulus: accept with grnt 01,10,01,10 (fills DEPTH=4), then 4 back-to-back responses D0..D3 with m_resp_ready=11.
  - Required: stall=1 after the 4th accept; outputs are D0→m0, D1→m1, D2→m0, D3→m1 on consecutive cycles.
- Backpressure:
  - Stimulus: 2 outstanding (m0,m1) with m_resp_ready=00; two responses offered.
  - Required: the first is captured and held on m_resp_valid=01 and s_resp_ready=0; after raising ready[0], the second appears on m1 one cycle later.
- Full with simultaneous pop:
  - Stimulus: count=4, then in the same cycle a response completes and another accept is attempted.
  - Required: no push; outstanding=3; err_grnt=1.
- Errors:
  - Stimulus: accept with grnt=11, then a response with the FIFO empty.
  - Required: err_grnt=1, err_orphan=1, m_resp_valid stays 00, outstanding stays 0.
- Reset mid-flight:
  - Stimulus: 3 outstanding plus a held output, then resetn pulled low asynchronously between clock edges.
  - Required: all outputs are 0 immediately; after release, a new accept/response pair works normally.
